aes_keyram_mc: RTL
==================

Name: aes_keyram_mc

Overview:
- Parametrised round-key store for the AES datapath. Holds SLOTS independent key schedules of up to NR_MAX round keys each.
- Streams round keys to the round engine, one key per key_ready pulse.
- Supports AES-128/192/256 (11/13/15 round keys), forward order for encryption and reverse order for decryption.
- Written by the key-expansion unit; read by the multi-cycle round core.

Parameters:
- KEY_W, 128: round-key word width.
- NR_MAX, 15: maximum round keys per slot (depth per slot).
- SLOTS, 2: number of independent key contexts.
- ADDR_W, 4: address width; must satisfy 2^ADDR_W >= NR_MAX.
- SLOT_W, 1: slot index width; must satisfy 2^SLOT_W >= SLOTS.

Ports:
- clk  in  1  clock, all logic on rising edge.
- kill  in  1  reset, synchronous, active-high.
- en_wr  in  1  write strobe.
- wr_slot  in  SLOT_W  slot being written.
- addr_wr  in  ADDR_W  round-key index being written.
- key_round_wr  in  KEY_W  round-key data.
- start  in  1  begin a read sequence (one-cycle pulse).
- rd_slot  in  SLOT_W  slot to read, sampled on start.
- nr_keys  in  ADDR_W+1  round-key count (11/13/15), sampled on start.
- dec  in  1  1 = reverse order, sampled on start.
- key_ready  in  1  advance to the next round key (pulse).
- key_round_rd  out  KEY_W  current round key, registered.
- key_vld  out  1  key_round_rd is valid.
- key_last  out  1  key_round_rd is the final key of the sequence.
- busy  out  1  a read sequence is active.
- start_err  out  1  one-cycle pulse: start rejected.
- slot_full  out  SLOTS  per slot, 1 when all NR_MAX keys are written.

Behaviour:
- Reset (kill=1 at a clock edge):
  - key_round_rd=0; key_vld, key_last, busy, start_err = 0.
  - Pointer = 0, FSM = IDLE.
  - Written-masks cleared, so slot_full = 0.
  - RAM contents are not cleared (BRAM-inferable). Reset mid-sequence aborts it immediately.
- Write path:
  - en_wr=1 with addr_wr < NR_MAX and wr_slot < SLOTS: stores data and sets mask bit [wr_slot][addr_wr].
  - A write with addr_wr=0 clears every other mask bit of that slot (new schedule begins).
  - Out-of-range address or slot: write ignored, no flag.
- Completeness check: slot s counts as complete for n keys when mask bits 0..n-1 are all set.
- Configuration on start: nr_keys outside {11,13,15} is treated as NR_MAX.
- FSM states: IDLE, LOAD, RUN.
  - IDLE -> LOAD on start when rd_slot is valid and complete for n. Latch slot, n, dec. Pointer = dec ? n-1 : 0.
  - IDLE -> IDLE on start when the slot is invalid or incomplete; start_err pulses next cycle.
  - LOAD -> RUN: RAM read is issued. key_round_rd and key_vld=1 appear 2 cycles after start (fixed latency).
  - RUN: key_ready moves the pointer (+1, or -1 when dec) and starts a new read; the new key appears 2 cycles after key_ready. key_vld drops for the intervening cycle.
  - key_last=1 while the presented key has index n-1 (forward) or 0 (dec).
  - key_ready while key_last=1 -> IDLE: key_vld, key_last, busy = 0; key_round_rd holds its value.
- key_ready in IDLE or LOAD: ignored.
- key_ready on consecutive cycles: each pulse is honoured. Pointer and output follow in order; key_vld stays low until the read pipeline settles.
- start while busy: restarts the sequence with new config (start wins over key_ready in the same cycle).
- busy=1 in LOAD and RUN.
- Write and read to the same slot/address in one cycle: read returns the old data (read-first).
- Writes to the active slot during RUN are allowed; keys not yet presented reflect the new data.

Optional Feature:
- Macro AES_KEYRAM_PARITY_EN.
- Defined:
  - One even-parity bit per 32-bit lane is stored alongside each word (KEY_W/32 bits).
  - The parity of each read word is checked when presented.
  - Extra output par_err (1 bit): 1-cycle pulse coinciding with key_vld rising on a mismatching word. Sticky until kill or next start.
- Not defined: no parity storage, no par_err port.

Decomposition:
- Package aes_keyram_pkg:
  - Constants NK_128=11, NK_192=13, NK_256=15.
  - FSM state enum {IDLE, LOAD, RUN}.
  - Function for parity per 32-bit lane.
- Sub-module aes_keyram_mem: simple dual-port RAM, depth SLOTS*NR_MAX, width KEY_W (+parity). Registered read, read-first, no reset of contents.

Test Plan:
- Fill slot 0 addr 0..10 with 128'h{addr}; start nr_keys=11, dec=0, then 11 key_ready pulses spaced 3 cycles -> keys 0..10 in order; key_last only on 10; 2-cycle latency each; busy falls after the 11th pulse.
- Same slot, dec=1 -> keys 10..0; key_last on key 0.
- Fill slot 1 with 15 keys; start nr_keys=15 on slot 1 while slot 0 is rewritten -> slot 1 sequence unaffected; slot_full=2'b10 mid-rewrite of slot 0.
- start on slot 0 after writing only addr 0..5, nr_keys=11 -> start_err pulse, busy stays 0; nr_keys=7 -> treated as 15, also rejected.
- During RUN at key 4, write addr 2 then addr 7 = 128'hff; then kill mid-sequence -> key 7 reads 128'hff; after kill all outputs are 0 and slot_full=0.
- AES_KEYRAM_PARITY_EN: force-corrupt stored word 3 via hierarchical access -> par_err pulses with key 3 and stays sticky until the next start.

Source files
------------

// File: rtl/aes_keyram_pkg.sv
// Shared constants, FSM state type and lane-parity helper for the AES round-key store.
// Combinational only; no latency.
// No flow control of its own.
package aes_keyram_pkg;

  localparam int NK_128 = 11;
  localparam int NK_192 = 13;
  localparam int NK_256 = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Even-parity bit for one 32-bit lane: stored bit makes the 33-bit group even.
  function automatic logic lane_par(input logic [31:0] lane);
    return ^lane;
  endfunction

endpackage

// File: rtl/aes_keyram_mem.sv
// Simple dual-port key RAM: one write port, one registered read port, no content reset.
// Read data appears one clock after rd_en/rd_addr; same-address write returns old data.
// No backpressure: both ports accept every cycle.
module aes_keyram_mem #(
  parameter int DW    = 128,
  parameter int DEPTH = 30,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dat
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_dat_q;

  // Write port; array is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

  // Registered read port; samples the array before a same-edge write lands (read-first).
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_dat_q <= mem_q[rd_addr];
    end
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/aes_keyram_mc.sv
// Multi-context AES round-key store: streams a slot's key schedule forward or reversed.
// First key 2 cycles after start, each next key 2 cycles after key_ready; key_vld low in between.
// key_ready advances the stream; writes always accepted. Optional lane parity: AES_KEYRAM_PARITY_EN.
module aes_keyram_mc
  import aes_keyram_pkg::*;
#(
  parameter int KEY_W  = 128,
  parameter int NR_MAX = 15,
  parameter int SLOTS  = 2,
  parameter int ADDR_W = 4,
  parameter int SLOT_W = 1
) (
  input  logic              clk,
  input  logic              kill,
  input  logic              en_wr,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [ADDR_W-1:0] addr_wr,
  input  logic [KEY_W-1:0]  key_round_wr,
  input  logic              start,
  input  logic [SLOT_W-1:0] rd_slot,
  input  logic [ADDR_W:0]   nr_keys,
  input  logic              dec,
  input  logic              key_ready,
  output logic [KEY_W-1:0]  key_round_rd,
  output logic              key_vld,
  output logic              key_last,
  output logic              busy,
  output logic              start_err,
  output logic [SLOTS-1:0]  slot_full
`ifdef AES_KEYRAM_PARITY_EN
  ,
  output logic              par_err
`endif
);

  localparam int DEPTH = SLOTS * NR_MAX;
  localparam int MA_W  = $clog2(DEPTH);
`ifdef AES_KEYRAM_PARITY_EN
  localparam int NLANE = KEY_W / 32;
  localparam int DW    = KEY_W + NLANE;
`else
  localparam int DW    = KEY_W;
`endif

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic              dec_q, dec_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              issue_q, issue_d;   // read address changed at the last edge
  logic              s1_q, s1_d;         // RAM output holds the word for the current pointer
  logic [KEY_W-1:0]  key_round_rd_q, key_round_rd_d;
  logic              key_vld_q, key_vld_d;
  logic              key_last_q, key_last_d;
  logic              start_err_q, start_err_d;
  logic [NR_MAX-1:0] mask_q [SLOTS];
  logic [NR_MAX-1:0] mask_d [SLOTS];

  logic [ADDR_W:0]   n_cfg;
  logic              slot_ok;
  logic              start_ok;
  logic [ADDR_W-1:0] first_idx;
  logic [ADDR_W-1:0] last_idx;
  logic              wr_ok;
  logic [MA_W-1:0]   wr_addr;
  logic [MA_W-1:0]   rd_addr;
  logic              rd_en;
  logic [DW-1:0]     wr_word;
  logic [DW-1:0]     rd_word;

  // Normalise the requested key count and decide whether the requested slot can be streamed.
  always_comb begin
    n_cfg = nr_keys;
    if (int'(nr_keys) != NK_128 && int'(nr_keys) != NK_192 && int'(nr_keys) != NK_256) begin
      n_cfg = (ADDR_W+1)'(NR_MAX);
    end
    if (int'(n_cfg) > NR_MAX) begin
      n_cfg = (ADDR_W+1)'(NR_MAX);
    end
    slot_ok  = int'(rd_slot) < SLOTS;
    start_ok = slot_ok;
    if (slot_ok) begin
      for (int i = 0; i < NR_MAX; i++) begin
        if (i < int'(n_cfg) && !mask_q[rd_slot][i]) begin
          start_ok = 1'b0;
        end
      end
    end
    first_idx = dec ? ADDR_W'(n_cfg - 1'b1) : '0;
  end

  // Address generation for both RAM ports; slot-major layout.
  always_comb begin
    wr_ok    = en_wr && (int'(addr_wr) < NR_MAX) && (int'(wr_slot) < SLOTS);
    wr_addr  = MA_W'(wr_slot) * MA_W'(NR_MAX) + MA_W'(addr_wr);
    rd_addr  = MA_W'(slot_q) * MA_W'(NR_MAX) + MA_W'(ptr_q);
    rd_en    = (state_q != IDLE);
    last_idx = dec_q ? '0 : ADDR_W'(n_q - 1'b1);
  end

  // Written-key masks: writing index 0 starts a fresh schedule for that slot.
  always_comb begin
    mask_d = mask_q;
    if (wr_ok) begin
      if (addr_wr == '0) begin
        mask_d[wr_slot] = '0;
      end
      mask_d[wr_slot][addr_wr] = 1'b1;
    end
  end

  // A slot is full once every one of its NR_MAX entries has been written.
  always_comb begin
    slot_full = '0;
    for (int s = 0; s < SLOTS; s++) begin
      slot_full[s] = &mask_q[s];
    end
  end

`ifdef AES_KEYRAM_PARITY_EN
  logic [NLANE-1:0] wr_par;
  logic [NLANE-1:0] rd_par;
  logic             par_bad;
  logic             par_err_q, par_err_d;

  // Per-lane parity generated on write and recomputed on the word coming out of the RAM.
  always_comb begin
    for (int l = 0; l < NLANE; l++) begin
      wr_par[l] = lane_par(key_round_wr[l*32 +: 32]);
      rd_par[l] = lane_par(rd_word[l*32 +: 32]);
    end
    wr_word = {wr_par, key_round_wr};
    par_bad = (rd_par != rd_word[DW-1:KEY_W]);
  end

  assign par_err = par_err_q;
`else
  assign wr_word = key_round_wr;
`endif

  aes_keyram_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (MA_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_dat  (wr_word),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_dat  (rd_word)
  );

  // Sequencer: start/advance handling, read-pipeline tracking and key presentation.
  always_comb begin
    state_d        = state_q;
    slot_d         = slot_q;
    n_d            = n_q;
    dec_d          = dec_q;
    ptr_d          = ptr_q;
    issue_d        = 1'b0;
    s1_d           = issue_q;
    key_round_rd_d = key_round_rd_q;
    key_vld_d      = key_vld_q;
    key_last_d     = key_last_q;
    start_err_d    = 1'b0;
`ifdef AES_KEYRAM_PARITY_EN
    par_err_d      = par_err_q;
`endif
    case (state_q)
      IDLE: begin
        s1_d = 1'b0;
      end
      LOAD: begin
        state_d = RUN;
      end
      RUN: begin
        if (key_ready) begin
          key_vld_d  = 1'b0;
          key_last_d = 1'b0;
          if (ptr_q == last_idx) begin
            // Final key consumed: drop back to idle, output data is left as is.
            state_d = IDLE;
            s1_d    = 1'b0;
          end else begin
            ptr_d   = dec_q ? ptr_q - 1'b1 : ptr_q + 1'b1;
            issue_d = 1'b1;
          end
        end else if (s1_q && !issue_q) begin
          // Only present once no newer read is in flight, so back-to-back
          // key_ready pulses surface just the most recent key.
          key_vld_d      = 1'b1;
          key_round_rd_d = rd_word[KEY_W-1:0];
          key_last_d     = (ptr_q == last_idx);
`ifdef AES_KEYRAM_PARITY_EN
          if (par_bad) begin
            par_err_d = 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // start overrides any key_ready in the same cycle, including mid-sequence restarts.
    if (start) begin
      if (start_ok) begin
        state_d    = LOAD;
        slot_d     = rd_slot;
        n_d        = n_cfg;
        dec_d      = dec;
        ptr_d      = first_idx;
        issue_d    = 1'b1;
        s1_d       = 1'b0;
        key_vld_d  = 1'b0;
        key_last_d = 1'b0;
`ifdef AES_KEYRAM_PARITY_EN
        par_err_d  = 1'b0;
`endif
      end else begin
        start_err_d = 1'b1;
      end
    end
  end

  // State registers; kill aborts any sequence and forgets all written schedules.
  always_ff @(posedge clk) begin
    if (kill) begin
      state_q        <= IDLE;
      slot_q         <= '0;
      n_q            <= '0;
      dec_q          <= 1'b0;
      ptr_q          <= '0;
      issue_q        <= 1'b0;
      s1_q           <= 1'b0;
      key_round_rd_q <= '0;
      key_vld_q      <= 1'b0;
      key_last_q     <= 1'b0;
      start_err_q    <= 1'b0;
      for (int s = 0; s < SLOTS; s++) begin
        mask_q[s] <= '0;
      end
`ifdef AES_KEYRAM_PARITY_EN
      par_err_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      slot_q         <= slot_d;
      n_q            <= n_d;
      dec_q          <= dec_d;
      ptr_q          <= ptr_d;
      issue_q        <= issue_d;
      s1_q           <= s1_d;
      key_round_rd_q <= key_round_rd_d;
      key_vld_q      <= key_vld_d;
      key_last_q     <= key_last_d;
      start_err_q    <= start_err_d;
      mask_q         <= mask_d;
`ifdef AES_KEYRAM_PARITY_EN
      par_err_q      <= par_err_d;
`endif
    end
  end

  assign key_round_rd = key_round_rd_q;
  assign key_vld      = key_vld_q;
  assign key_last     = key_last_q;
  assign busy         = (state_q != IDLE);
  assign start_err    = start_err_q;

endmodule
